// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard/sequencing controller.
// The pipeline (master) presents ID/EX hazard information; the controller (slave) returns enables and statistics.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // Hazard information presented by the pipeline
  logic [1:0]       ID_rs;
  logic [1:0]       ID_rt;
  logic             ID_use_rs;
  logic             ID_use_rt;
  logic             ID_jump;
  logic             ID_halt;
  logic             EX_MemRead;
  logic [1:0]       EX_rd;
  logic             EX_branch_taken;
  logic             imem_ready;

  // Sequencing decisions and statistics returned by the controller
  logic             PC_WriteEn;
  logic             IFID_WriteEn;
  logic             IF_flush;
  logic             IDEX_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic [1:0]       state_dbg;

  modport master (
    output ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_jump, ID_halt,
           EX_MemRead, EX_rd, EX_branch_taken, imem_ready,
    input  PC_WriteEn, IFID_WriteEn, IF_flush, IDEX_bubble, halted,
           stall_count, flush_count, state_dbg
  );

  modport slave (
    input  ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_jump, ID_halt,
           EX_MemRead, EX_rd, EX_branch_taken, imem_ready,
    output PC_WriteEn, IFID_WriteEn, IF_flush, IDEX_bubble, halted,
           stall_count, flush_count, state_dbg
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: decides advance/hold/flush of PC and IF/ID, bubble into ID/EX,
// and keeps saturating stall/flush statistics.
module hazard_ctrl #(
  parameter int LOADUSE_STALL = 1,
  parameter int CNT_W         = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [2:0]       lu_cnt, lu_nx;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             stall_inc, flush_inc;
  logic             lu;

  // Fetch handshake: imem_ready=1 means the instruction presented to IF/ID this cycle is valid;
  // when it is low a NOP is written into ID while the PC holds, so the miss behaves like a stall.
  assign lu = bus.EX_MemRead &
              ((bus.ID_use_rs & (bus.ID_rs == bus.EX_rd)) |
               (bus.ID_use_rt & (bus.ID_rt == bus.EX_rd)));

  always_comb begin
    state_nx         = state;
    lu_nx            = lu_cnt;
    stall_inc        = 1'b0;
    flush_inc        = 1'b0;
    bus.PC_WriteEn   = 1'b0;
    bus.IFID_WriteEn = 1'b0;
    bus.IF_flush     = 1'b0;
    bus.IDEX_bubble  = 1'b0;
    bus.halted       = 1'b0;

    if (!reset_n) begin
      bus.IF_flush    = 1'b1;
      bus.IDEX_bubble = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (bus.EX_branch_taken) begin
            // Whatever sits in ID is on the wrong path, so its hazards are irrelevant.
            bus.PC_WriteEn   = 1'b1;
            bus.IFID_WriteEn = 1'b1;
            bus.IF_flush     = 1'b1;
            bus.IDEX_bubble  = 1'b1;
            flush_inc        = 1'b1;
          end else if (bus.ID_halt) begin
            state_nx = HALT;
          end else if (lu) begin
            bus.IDEX_bubble = 1'b1;
            stall_inc       = 1'b1;
            if (LOADUSE_STALL > 1) begin
              lu_nx    = 3'(LOADUSE_STALL - 1);
              state_nx = LU_STALL;
            end
          end else if (bus.ID_jump) begin
            bus.PC_WriteEn   = 1'b1;
            bus.IFID_WriteEn = 1'b1;
            bus.IF_flush     = 1'b1;
            flush_inc        = 1'b1;
          end else if (!bus.imem_ready) begin
            bus.IFID_WriteEn = 1'b1;
            bus.IF_flush     = 1'b1;
            stall_inc        = 1'b1;
          end else begin
            bus.PC_WriteEn   = 1'b1;
            bus.IFID_WriteEn = 1'b1;
          end
        end

        LU_STALL: begin
          // EX holds a bubble here, so no branch can resolve and inputs are ignored.
          bus.IDEX_bubble = 1'b1;
          stall_inc       = 1'b1;
          lu_nx           = lu_cnt - 3'd1;
          if (lu_cnt == 3'd1) state_nx = RUN;
        end

        HALT: begin
          bus.IDEX_bubble = 1'b1;
          bus.halted      = 1'b1;
        end

        default: begin
          state_nx = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= RUN;
      lu_cnt    <= 3'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= state_nx;
      lu_cnt <= lu_nx;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_count = stall_cnt;
  assign bus.flush_count = flush_cnt;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (load-use stall 1, 3, 5) share one stimulus stream;
// a scoreboard queue holds per-instance expected outputs checked on the falling edge.
module tb_hazard_ctrl;

  localparam int VW = 39;  // {state[1:0], pc, ifid, flush, bubble, halted, stall[15:0], flush[15:0]}

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] id_rs, id_rt, ex_rd;
  logic       id_use_rs, id_use_rt, id_jump, id_halt, ex_memread, ex_branch, imem_ready;

  logic [VW-1:0] obs [3];
  logic [VW-1:0] exp_q [$];

  int n_vec  = 0;
  int n_miss = 0;

  // Reference state per instance
  int lstall [3] = '{1, 3, 5};
  int m_st   [3];
  int m_lu   [3];
  int m_sc   [3];
  int m_fc   [3];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    hazard_ctrl_if #(.CNT_W(16)) hif ();

    assign hif.ID_rs           = id_rs;
    assign hif.ID_rt           = id_rt;
    assign hif.ID_use_rs       = id_use_rs;
    assign hif.ID_use_rt       = id_use_rt;
    assign hif.ID_jump         = id_jump;
    assign hif.ID_halt         = id_halt;
    assign hif.EX_MemRead      = ex_memread;
    assign hif.EX_rd           = ex_rd;
    assign hif.EX_branch_taken = ex_branch;
    assign hif.imem_ready      = imem_ready;

    hazard_ctrl #(
      .LOADUSE_STALL((g == 0) ? 1 : (g == 1) ? 3 : 5),
      .CNT_W(16)
    ) u_dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (hif.slave)
    );

    assign obs[g] = {hif.state_dbg, hif.PC_WriteEn, hif.IFID_WriteEn, hif.IF_flush,
                     hif.IDEX_bubble, hif.halted, hif.stall_count, hif.flush_count};
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack(input int st, input logic pc, input logic ifid,
                                         input logic fl, input logic bub, input logic hl,
                                         input int sc, input int fc);
    return {2'(st), pc, ifid, fl, bub, hl, 16'(sc), 16'(fc)};
  endfunction

  // Expected outputs for the current inputs, then advance the reference state one clock.
  task automatic model_step(input int i, output logic [VW-1:0] e);
    logic lu;
    lu = ex_memread && ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    if (!reset_n) begin
      e = pack(m_st[i], 0, 0, 1, 1, 0, m_sc[i], m_fc[i]);
      m_st[i] = 0; m_lu[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
      return;
    end
    if (m_st[i] == 2) begin
      e = pack(2, 0, 0, 0, 1, 1, m_sc[i], m_fc[i]);
    end else if (m_st[i] == 1) begin
      e = pack(1, 0, 0, 0, 1, 0, m_sc[i], m_fc[i]);
      if (m_sc[i] < 65535) m_sc[i]++;
      m_lu[i]--;
      if (m_lu[i] == 0) m_st[i] = 0;
    end else if (ex_branch) begin
      e = pack(0, 1, 1, 1, 1, 0, m_sc[i], m_fc[i]);
      if (m_fc[i] < 65535) m_fc[i]++;
    end else if (id_halt) begin
      e = pack(0, 0, 0, 0, 0, 0, m_sc[i], m_fc[i]);
      m_st[i] = 2;
    end else if (lu) begin
      e = pack(0, 0, 0, 0, 1, 0, m_sc[i], m_fc[i]);
      if (m_sc[i] < 65535) m_sc[i]++;
      if (lstall[i] > 1) begin
        m_st[i] = 1;
        m_lu[i] = lstall[i] - 1;
      end
    end else if (id_jump) begin
      e = pack(0, 1, 1, 1, 0, 0, m_sc[i], m_fc[i]);
      if (m_fc[i] < 65535) m_fc[i]++;
    end else if (!imem_ready) begin
      e = pack(0, 0, 1, 1, 0, 0, m_sc[i], m_fc[i]);
      if (m_sc[i] < 65535) m_sc[i]++;
    end else begin
      e = pack(0, 1, 1, 0, 0, 0, m_sc[i], m_fc[i]);
    end
  endtask

  // One clock: push expectations, compare on the falling edge, then cross the rising edge.
  task automatic step(input string tag);
    logic [VW-1:0] e;
    for (int i = 0; i < 3; i++) begin
      model_step(i, e);
      exp_q.push_back(e);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL %s_u%0d: scoreboard empty", tag, i);
      end else begin
        e = exp_q.pop_front();
        check_eq($sformatf("%s_u%0d", tag, i), 64'(obs[i]), 64'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    reset_n = 1'b1; id_rs = 2'd0; id_rt = 2'd0; ex_rd = 2'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_jump = 1'b0; id_halt = 1'b0;
    ex_memread = 1'b0; ex_branch = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic drive_rand();
    id_rs = 2'($urandom_range(0, 3)); id_rt = 2'($urandom_range(0, 3));
    ex_rd = 2'($urandom_range(0, 3));
    id_use_rs = 1'($urandom_range(0, 1)); id_use_rt = 1'($urandom_range(0, 1));
    id_jump = ($urandom_range(0, 3) == 0); id_halt = ($urandom_range(0, 15) == 0);
    ex_memread = ($urandom_range(0, 2) == 0); ex_branch = ($urandom_range(0, 5) == 0);
    imem_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive_lu();
    drive_idle();
    ex_memread = 1'b1; ex_rd = 2'd2; id_use_rt = 1'b1; id_rt = 2'd2;
  endtask

  task automatic do_reset(input string tag);
    drive_rand();
    reset_n = 1'b0;
    step(tag);
  endtask

  // ---------------- sequence ----------------
  initial begin
    for (int i = 0; i < 3; i++) begin
      m_st[i] = 0; m_lu[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end
    drive_idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    do_reset("rst0");
    do_reset("rst1");
    check_eq("rst_flush", 64'(obs[0][34]), 64'd1);
    check_eq("rst_pc_we", 64'(obs[0][36]), 64'd0);
    drive_idle();
    step("idle");
    check_eq("post_rst_pc", 64'(obs[0][36]), 64'd1);

    // Load-use: stall length per instance
    drive_lu();
    step("lu");
    drive_idle();
    repeat (7) step("lu_drain");
    check_eq("lu1_stall", 64'(obs[0][31:16]), 64'd1);
    check_eq("lu3_stall", 64'(obs[1][31:16]), 64'd3);
    check_eq("lu5_stall", 64'(obs[2][31:16]), 64'd5);

    // Branch outranks load-use and halt in ID
    do_reset("rst_br");
    drive_lu();
    id_halt = 1'b1;
    ex_branch = 1'b1;
    step("br_prio");
    drive_idle();
    step("br_after");
    check_eq("br_flushcnt", 64'(obs[1][15:0]), 64'd1);
    check_eq("br_stallcnt", 64'(obs[1][31:16]), 64'd0);
    check_eq("br_halted", 64'(obs[1][32]), 64'd0);

    // Jump then fetch misses
    do_reset("rst_jmp");
    drive_idle();
    id_jump = 1'b1;
    step("jump");
    drive_idle();
    imem_ready = 1'b0;
    repeat (4) step("miss");
    check_eq("miss_stallcnt", 64'(obs[0][31:16]), 64'd4);
    check_eq("miss_flushcnt", 64'(obs[0][15:0]), 64'd1);

    // Halt is sticky until reset
    drive_idle();
    id_halt = 1'b1;
    step("halt");
    for (int k = 0; k < 10; k++) begin
      drive_rand();
      reset_n = 1'b1;
      step("halt_hold");
    end
    check_eq("halt_stays", 64'(obs[2][32]), 64'd1);
    do_reset("rst_halt");
    drive_idle();
    step("halt_clr");
    check_eq("halt_cleared", 64'(obs[2][32]), 64'd0);

    // Reset during the second stall cycle of the 5-cycle instance
    drive_lu();
    step("mid_lu");
    do_reset("mid_rst");
    drive_idle();
    step("mid_after");
    check_eq("mid_state", 64'(obs[2][38:37]), 64'd0);
    check_eq("mid_stallcnt", 64'(obs[2][31:16]), 64'd0);

    // Random mix
    for (int k = 0; k < 300; k++) begin
      drive_rand();
      reset_n = ($urandom_range(0, 31) != 0);
      step("rand");
    end

    // Stall counter saturation
    do_reset("rst_sat");
    drive_idle();
    imem_ready = 1'b0;
    for (int k = 0; k < 65540; k++) step("sat");
    check_eq("sat_stallcnt", 64'(obs[0][31:16]), 64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
